// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// The state encoding and the byte width are kept here so they have a single definition.
package uart_tx_scheduler_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_ARB,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_baud_tick.sv
// Free-running bit-rate strobe for uart_send: one CLK-wide tick every BAUD_DIV cycles.
// The first tick appears on the BAUD_DIV-th cycle after reset release.
module uart_baud_tick #(
    parameter int BAUD_DIV = 5
) (
    input  logic CLK,
    input  logic RST_N,
    output logic TICK
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign TICK = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_send transmitter among NUM_REQ byte requesters,
// with per-requester packet lock, baud tick generation and a start-of-frame watchdog.
//
// state         | meaning
// --------------+------------------------------------------------------------
// ST_ARB        | pick locked owner or next RR requester; latch grant and byte
// ST_ISSUE      | DATA_READY and ACK visible this cycle; advance RR pointer
// ST_WAIT_START | wait for uart_send to leave idle; watchdog runs
// ST_WAIT_DONE  | wait for stop bit to finish; keep grant if LOCK is high
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int BAUD_DIV = 5,
    parameter int TO_CYC   = 2 * BAUD_DIV + 2
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_REQ-1:0]             REQ,
    input  logic [NUM_REQ-1:0]             LOCK,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]             ACK,
    output logic [NUM_REQ-1:0]             GRANT,
    output logic [UART_BYTE_W-1:0]         TX_DATA,
    output logic                           TX_DATA_READY,
    input  logic                           TX_IDLE,
    output logic                           UART_CLK,
    output logic                           FAULT
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    // ISSUE and the terminal-count cycle account for two of the TO_CYC cycles.
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_CYC - 2);

    sched_state_t      state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  rr_ptr;
    logic [TO_W-1:0]   timer;

    logic [IDX_W:0]    rr_sel;
    logic              lock_hit;
    logic              next_valid;
    logic [IDX_W-1:0]  next_idx;
    logic [NUM_REQ-1:0] next_oh;

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0]   pick;
        logic [IDX_W-1:0] idx;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .CLK  (CLK),
        .RST_N(RST_N),
        .TICK (UART_CLK)
    );

    always_comb begin
        rr_sel     = rr_pick(REQ, rr_ptr);
        lock_hit   = (GRANT != '0) && REQ[owner];
        next_idx   = lock_hit ? owner : rr_sel[IDX_W-1:0];
        next_valid = lock_hit || rr_sel[IDX_W];
        next_oh    = '0;
        next_oh[next_idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= ST_ARB;
            owner         <= '0;
            rr_ptr        <= '0;
            timer         <= '0;
            GRANT         <= '0;
            ACK           <= '0;
            TX_DATA       <= '0;
            TX_DATA_READY <= 1'b0;
            FAULT         <= 1'b0;
        end else begin
            ACK           <= '0;
            TX_DATA_READY <= 1'b0;
            FAULT         <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (next_valid) begin
                        owner         <= next_idx;
                        GRANT         <= next_oh;
                        TX_DATA       <= REQ_DATA[next_idx*UART_BYTE_W +: UART_BYTE_W];
                        ACK           <= next_oh;
                        TX_DATA_READY <= 1'b1;
                        state         <= ST_ISSUE;
                    end else begin
                        GRANT <= '0;
                    end
                end
                ST_ISSUE: begin
                    rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    timer  <= TO_LOAD;
                    state  <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (!TX_IDLE) begin
                        state <= ST_WAIT_DONE;
                    end else if (timer == '0) begin
                        FAULT <= 1'b1;
                        GRANT <= '0;
                        state <= ST_ARB;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (TX_IDLE) begin
                        if (!LOCK[owner]) begin
                            GRANT <= '0;
                        end
                        state <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single uart_send transmitter among NUM_REQ byte-stream requesters using round-robin arbitration with optional per-requester lock for multi-byte packets. Generates the UART_CLK bit-rate tick that uart_send consumes. Sequences each byte into uart_send with a one-cycle DATA_READY pulse. Tracks uart_send IDLE so the next byte is issued only after the previous stop bit completes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BAUD_DIV, 5, CLK cycles per UART bit; UART_CLK period
TO_CYC, 2*BAUD_DIV+2, cycles to wait for TX_IDLE to fall after a DATA_READY pulse before declaring a fault

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
REQ  in  NUM_REQ  requester i has a byte pending; held until its ACK
LOCK  in  NUM_REQ  requester i keeps the grant after its current byte (packet continuation)
REQ_DATA  in  8*NUM_REQ  byte of requester i at [8i+7:8i]; stable while REQ[i]
ACK  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
GRANT  out  NUM_REQ  one-hot current owner; all-zero when no owner
TX_DATA  out  8  byte to uart_send DATA
TX_DATA_READY  out  1  one-cycle pulse to uart_send DATA_READY
TX_IDLE  in  1  uart_send IDLE
UART_CLK  out  1  one-CLK-wide tick every BAUD_DIV cycles, to uart_send UART_CLK
FAULT  out  1  one-cycle pulse on TO_CYC timeout

Behaviour:
- Reset (async, RST_N low): ACK=0, GRANT=0, TX_DATA=0, TX_DATA_READY=0, FAULT=0, UART_CLK=0, baud counter=0, RR pointer=0, state=ARB. Release mid-transfer: state restarts at ARB; no ACK for an interrupted byte; the requester's REQ stays high and is re-served.
- Baud tick: counter 0..BAUD_DIV-1, free-running; UART_CLK=1 for exactly the cycle when counter==BAUD_DIV-1. First tick on the BAUD_DIV-th cycle after reset release. Independent of the FSM.
- FSM states: ARB, ISSUE, WAIT_START, WAIT_DONE.
- ARB: if GRANT!=0 (locked owner) and REQ[owner], serve the owner. Otherwise choose the first i with REQ[i]=1, searching from RR pointer upward with wrap. If no request, stay; GRANT=0. Otherwise register GRANT=onehot(i) and TX_DATA=REQ_DATA[i]; go ISSUE next cycle.
- ISSUE (1 cycle): TX_DATA_READY=1, ACK[i]=1; RR pointer=(i+1) mod NUM_REQ; go WAIT_START.
- WAIT_START: TX_DATA held. TX_IDLE==0 -> WAIT_DONE. Timeout counter reaches TO_CYC -> FAULT pulse, GRANT=0, go ARB.
- WAIT_DONE: TX_DATA held. When TX_IDLE==1: if LOCK[i]==1, keep GRANT; else GRANT=0. Go ARB.
- Locked owner whose REQ drops while LOCK is high: the lock is released at ARB and normal RR applies.
- ACK is never asserted for two requesters in the same cycle. Exactly one TX_DATA_READY pulse per ACK. Minimum spacing between pulses is one full uart_send frame.
- Simultaneous REQ rise and locked owner: the owner wins; others wait regardless of the RR pointer.
- TX_DATA is registered. It changes only in ARB on a new grant and is otherwise stable.

Decomposition:
- Shared package: FSM state encoding (ARB/ISSUE/WAIT_START/WAIT_DONE) and the UART byte width constant (8).
- One sub-module, uart_baud_tick (parameter BAUD_DIV; ports CLK, RST_N, TICK), instantiated for UART_CLK.
- RR search is a function inside the scheduler.

Test Plan:
1. Reset, then REQ[0]=1 with 0xAA; uart_send model drops IDLE on the next tick -> GRANT=0001, ACK[0] and TX_DATA_READY pulse the same cycle with TX_DATA=0xAA. No further pulse until IDLE is high again. UART_CLK period is 5 cycles throughout.
2. REQ=1111 simultaneously, bytes 0x10,0x21,0x32,0x43 -> ACK order 0,1,2,3. TX_DATA sequence 0x10,0x21,0x32,0x43. RR pointer returns to 0.
3. Requester 2 sends 0x4C,0x55,0x66 with LOCK[2]=1 for the first two bytes; REQ[1] is high throughout -> all three bytes from requester 2 go consecutively, then requester 1 is served.
4. TX_IDLE tied high -> FAULT pulses 12 cycles after TX_DATA_READY. GRANT=0, and the next pending requester is served normally.
5. RST_N asserted during WAIT_DONE -> all outputs 0 asynchronously. After release, the still-high REQ is re-granted with its unchanged byte.
6. uart_send connected end-to-end with bytes 0xAA then 0x4C -> TXD frames are start, LSB-first data, stop at 5-cycle bit time, with no gap overlap.
